// File: rtl/md_timestep_scheduler.sv
// Phase sequencer for one MD timestep loop: force pipeline, position update,
// then a double-buffer swap, repeated for a latched number of steps.
module md_timestep_scheduler #(
  parameter int STEP_W        = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 65536,
  parameter int TO_W          = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  output logic              force_start,
  input  logic              force_done,
  output logic              pu_ready,
  input  logic              pu_done,
  output logic              double_buffer,
  output logic [1:0]        block,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FORCE_KICK,
    S_FORCE_WAIT,
    S_UPDATE,
    S_SWAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [STEP_W-1:0] n_steps;
  logic [TO_W-1:0]   wd_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              active, in_wait, timeout_hit, accept;

  assign active  = (state != S_IDLE) && (state != S_ERROR);
  assign in_wait = (state == S_FORCE_WAIT) || (state == S_UPDATE);

  // Next-state selection; the if/else order encodes abort > timeout > done > start.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    timeout_hit = (TIMEOUT != 0) && in_wait && (wd_cnt == TO_LAST);
    if (active && abort) begin
      state_n = S_IDLE;
    end else if (timeout_hit) begin
      state_n = S_ERROR;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            accept  = 1'b1;
            state_n = (num_steps == '0) ? S_DONE : S_FORCE_KICK;
          end
        end
        S_FORCE_KICK: state_n = S_FORCE_WAIT;
        S_FORCE_WAIT: if (force_done) state_n = S_UPDATE;
        S_UPDATE:     if (pu_done) state_n = S_SWAP;
        S_SWAP: begin
          if (settle_cnt == SETTLE_LAST)
            state_n = (step_count == n_steps) ? S_DONE : S_FORCE_KICK;
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      n_steps       <= '0;
      wd_cnt        <= '0;
      settle_cnt    <= '0;
      force_start   <= 1'b0;
      pu_ready      <= 1'b0;
      double_buffer <= 1'b0;
      block         <= 2'b00;
      step_count    <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      error         <= 1'b0;
    end else begin
      state <= state_n;

      if (state_n != state)
        wd_cnt <= '0;
      else if (in_wait)
        wd_cnt <= wd_cnt + 1'b1;

      if (state_n != state)
        settle_cnt <= '0;
      else if (state == S_SWAP)
        settle_cnt <= settle_cnt + 1'b1;

      if (accept) begin
        n_steps    <= num_steps;
        step_count <= '0;
        error      <= 1'b0;
      end

      if (state_n == S_ERROR)
        error <= 1'b1;

      // Bank flip and step count happen only on the first SWAP cycle.
      if ((state_n == S_SWAP) && (state != S_SWAP)) begin
        double_buffer <= ~double_buffer;
        step_count    <= step_count + 1'b1;
      end

      force_start <= (state_n == S_FORCE_KICK);
      pu_ready    <= (state_n == S_UPDATE);
      finished    <= (state_n == S_DONE);
      busy        <= (state_n != S_IDLE) && (state_n != S_ERROR);

      case (state_n)
        S_FORCE_KICK, S_FORCE_WAIT: block <= 2'b01;
        S_UPDATE:                   block <= 2'b10;
        S_SWAP:                     block <= 2'b11;
        default:                    block <= 2'b00;
      endcase
    end
  end

endmodule
